f2c_pkt_drain: RTL
==================

Name: f2c_pkt_drain

Overview:
Downstream consumer of the F2C packet ring buffer (flit_lite_t) and descriptor ring buffer (pkt_desc_t) that the PDU generator fills.
- Pops one descriptor, then pops exactly desc.size flits from the packet buffer.
- Checks sop/eop framing against the descriptor size.
- Emits a clean, tagged valid/ready flit stream to the DMA/TLP stage.
- Malformed packets are repaired or dropped, so the downstream stream is always well framed.

Parameters:
APP_IDX_WIDTH, 10, width of dsc_queue_id
FLOW_IDX_WIDTH, 13, width of pkt_queue_id
SIZE_WIDTH, 16, width of descriptor size field (flits)
ERR_CNT_WIDTH, 32, width of error counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
pkt_buf_rd_data  in  514  show-ahead head flit {data[511:0], sop, eop}
pkt_buf_empty  in  1  packet buffer empty
pkt_buf_rd_en  out  1  pop packet buffer (combinational)
desc_buf_rd_data  in  APP_IDX_WIDTH+FLOW_IDX_WIDTH+SIZE_WIDTH  show-ahead head descriptor {dsc_queue_id, pkt_queue_id, size}
desc_buf_empty  in  1  descriptor buffer empty
desc_buf_rd_en  out  1  pop descriptor buffer (combinational)
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  512  flit payload
out_sop  out  1  first beat of packet
out_eop  out  1  last beat of packet
out_err  out  1  packet framing was repaired (valid with out_eop)
out_dsc_queue_id  out  APP_IDX_WIDTH  descriptor queue tag, constant across packet
out_pkt_queue_id  out  FLOW_IDX_WIDTH  packet queue tag, constant across packet
out_size  out  SIZE_WIDTH  descriptor size, constant across packet
err_cnt  out  ERR_CNT_WIDTH  saturating framing-error count
stat_pkt_cnt  out  32  see Optional Feature
stat_flit_cnt  out  32  see Optional Feature

Behaviour:
- Reset (rst_n==0 at posedge): state IDLE; all outputs 0 including err_cnt and stat counters; no pops.
  - Reset mid-packet abandons the packet. Buffer resync is the owner's job; the buffers are reset together.
- Output register: one stage. `adv = !out_valid || out_ready`. A flit is popped only when adv==1 and !pkt_buf_empty. Output holds stable while out_valid && !out_ready.
- State IDLE:
  - If !desc_buf_empty: desc_buf_rd_en=1 for that cycle; latch descriptor; rem = size; go to STREAM.
  - If size==0: pop the descriptor, err_cnt+1, stay IDLE; no flits are consumed.
- State STREAM (rem = remaining flits; first = rem==size). Each popped flit:
  - First flit without sop: discard it (not forwarded), err_cnt+1, go to DROP.
  - Normal beat: forward with out_sop=first, rem-1.
  - eop with rem>1 (early eop): forward with out_eop=1, out_err=1, err_cnt+1, go to IDLE.
  - rem==1 and eop: forward with out_eop=1, go to IDLE.
  - rem==1 and no eop (long packet): forward with out_eop forced 1, out_err=1, err_cnt+1, go to DROP.
  - sop seen on a non-first flit: ignored; forwarded with out_sop=0.
- State DROP: pop flits whenever !pkt_buf_empty regardless of out_ready; discard them; on the eop flit go to IDLE.
- Latency: descriptor popped in cycle N; first flit popped no earlier than N+1; out_valid asserts at N+2.
  - Back-to-back packets: at most one idle output cycle between eop and the next sop (the IDLE cycle).
  - No bubbles within a packet while out_ready=1 and the packet buffer is non-empty.
- Descriptor pop and flit pop never occur in the same cycle.
- err_cnt saturates at all-ones.
- out_err is 0 on all non-eop beats.

Optional Feature:
Macro F2C_DRAIN_STATS_EN.
- Defined: stat_pkt_cnt increments on each accepted eop beat (out_valid && out_ready && out_eop); stat_flit_cnt increments on each accepted beat. Both are 32-bit wrap-around counters, reset to 0.
- Undefined: both ports are tied to 0 and the counter logic is absent.

Test Plan:
1. desc {dsc=3, pkt=7, size=1}, one flit with sop=eop=1, out_ready=1 -> one beat with out_sop=out_eop=1, out_dsc_queue_id=3, out_pkt_queue_id=7, out_err=0, valid 2 cycles after the descriptor pop.
2. Sizes 2, 4, 1 queued back-to-back, out_ready=1 -> 7 beats, sop/eop at beats 1/2, 3/6, 7/7; exactly one idle cycle between packets; err_cnt=0.
3. Size 4, out_ready toggling 1,0,0,1,... -> no pkt_buf_rd_en while stalled, out_data stable; all 4 flits delivered in order.
4. size=3 with eop on flit 2 -> beat 2 has out_eop=1, out_err=1, err_cnt=1; next descriptor's packet is delivered clean.
5. size=2 with a 4-flit packet -> beat 2 has forced eop and out_err=1; flits 3-4 popped but not output; err_cnt=1.
6. size=0 descriptor -> descriptor popped, no flit popped, err_cnt=1. Then rst_n=0 mid-packet -> all outputs 0 the next cycle, no pops.

Source files
------------

// File: rtl/f2c_pkt_drain.sv
// f2c_pkt_drain: drains the F2C descriptor and packet ring buffers and emits
// a well-framed, tagged valid/ready flit stream toward the DMA/TLP stage.
// Each descriptor announces the packet size in flits. Flits are checked
// against that size. A packet that ends early or runs long is repaired by
// forcing eop and raising out_err. A packet whose first flit lacks sop is
// dropped through its eop.
// Optional feature macro: F2C_DRAIN_STATS_EN enables the accepted packet and
// flit counters. When the macro is undefined, both stat ports read 0.
module f2c_pkt_drain #(
   parameter int APP_IDX_WIDTH  = 10,
   parameter int FLOW_IDX_WIDTH = 13,
   parameter int SIZE_WIDTH     = 16,
   parameter int ERR_CNT_WIDTH  = 32
) (
   input  logic                                              clk,
   input  logic                                              rst_n,
   input  logic [513:0]                                      pkt_buf_rd_data,
   input  logic                                              pkt_buf_empty,
   output logic                                              pkt_buf_rd_en,
   input  logic [APP_IDX_WIDTH+FLOW_IDX_WIDTH+SIZE_WIDTH-1:0] desc_buf_rd_data,
   input  logic                                              desc_buf_empty,
   output logic                                              desc_buf_rd_en,
   output logic                                              out_valid,
   input  logic                                              out_ready,
   output logic [511:0]                                      out_data,
   output logic                                              out_sop,
   output logic                                              out_eop,
   output logic                                              out_err,
   output logic [APP_IDX_WIDTH-1:0]                          out_dsc_queue_id,
   output logic [FLOW_IDX_WIDTH-1:0]                         out_pkt_queue_id,
   output logic [SIZE_WIDTH-1:0]                             out_size,
   output logic [ERR_CNT_WIDTH-1:0]                          err_cnt,
   output logic [31:0]                                       stat_pkt_cnt,
   output logic [31:0]                                       stat_flit_cnt
);

   typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DROP = 2'd2} state_t;

   state_t                    state_reg, state_next;
   logic [SIZE_WIDTH-1:0]     rem_reg, rem_next;
   logic [SIZE_WIDTH-1:0]     size_reg, size_next;
   logic [APP_IDX_WIDTH-1:0]  dsc_reg, dsc_next;
   logic [FLOW_IDX_WIDTH-1:0] pq_reg, pq_next;

   // Head flit and head descriptor fields.
   logic [511:0]              flit_data;
   logic                      flit_sop, flit_eop;
   logic [SIZE_WIDTH-1:0]     desc_size;
   logic [FLOW_IDX_WIDTH-1:0] desc_pq;
   logic [APP_IDX_WIDTH-1:0]  desc_dsc;

   assign flit_data = pkt_buf_rd_data[513:2];
   assign flit_sop  = pkt_buf_rd_data[1];
   assign flit_eop  = pkt_buf_rd_data[0];
   assign desc_size = desc_buf_rd_data[SIZE_WIDTH-1:0];
   assign desc_pq   = desc_buf_rd_data[FLOW_IDX_WIDTH+SIZE_WIDTH-1:SIZE_WIDTH];
   assign desc_dsc  = desc_buf_rd_data[APP_IDX_WIDTH+FLOW_IDX_WIDTH+SIZE_WIDTH-1:FLOW_IDX_WIDTH+SIZE_WIDTH];

   logic adv, first, last, desc_pop, flit_pop, fwd, beat_eop, beat_err, err_inc;

   // Output register state.
   logic                      out_valid_reg, out_sop_reg, out_eop_reg, out_err_reg;
   logic [511:0]              out_data_reg;
   logic [APP_IDX_WIDTH-1:0]  out_dsc_reg;
   logic [FLOW_IDX_WIDTH-1:0] out_pq_reg;
   logic [SIZE_WIDTH-1:0]     out_size_reg;
   logic [ERR_CNT_WIDTH-1:0]  err_cnt_reg;

   // State register: FSM state plus the latched descriptor and remaining count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         rem_reg   <= '0;
         size_reg  <= '0;
         dsc_reg   <= '0;
         pq_reg    <= '0;
      end else begin
         state_reg <= state_next;
         rem_reg   <= rem_next;
         size_reg  <= size_next;
         dsc_reg   <= dsc_next;
         pq_reg    <= pq_next;
      end
   end

   // Next-state logic: descriptor latch, flit countdown and framing exits.
   always_comb begin
      state_next = state_reg;
      rem_next   = rem_reg;
      size_next  = size_reg;
      dsc_next   = dsc_reg;
      pq_next    = pq_reg;
      case (state_reg)
         IDLE: begin
            // A zero-size descriptor is consumed and counted, but it does not start a packet.
            if (desc_pop && desc_size != '0) begin
               size_next  = desc_size;
               rem_next   = desc_size;
               dsc_next   = desc_dsc;
               pq_next    = desc_pq;
               state_next = STREAM;
            end
         end
         STREAM: begin
            if (flit_pop) begin
               if (first && !flit_sop) begin
                  // A sop-less first flit that also carries eop is the whole bad
                  // packet, so there is nothing left to drain.
                  state_next = flit_eop ? IDLE : DROP;
               end else if (flit_eop) begin
                  state_next = IDLE;
               end else if (last) begin
                  state_next = DROP;
               end else begin
                  rem_next = rem_reg - 1'b1;
               end
            end
         end
         DROP: begin
            if (flit_pop && flit_eop)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Output decode: pop strobes, forward decision and framing repair flags.
   always_comb begin
      adv      = !out_valid_reg || out_ready;
      first    = (rem_reg == size_reg);
      last     = (rem_reg == SIZE_WIDTH'(1));
      desc_pop = rst_n && (state_reg == IDLE) && !desc_buf_empty;
      // In DROP, flits are discarded and never touch the output register, so
      // backpressure does not apply.
      flit_pop = rst_n && !pkt_buf_empty &&
                 (((state_reg == STREAM) && adv) || (state_reg == DROP));
      fwd      = (state_reg == STREAM) && flit_pop && !(first && !flit_sop);
      beat_eop = flit_eop || last;
      // Set when eop arrives early, or when it is missing on the last counted flit.
      beat_err = flit_eop != last;
      err_inc  = (desc_pop && desc_size == '0) ||
                 ((state_reg == STREAM) && flit_pop && first && !flit_sop) ||
                 (fwd && beat_err);
   end

   assign pkt_buf_rd_en  = flit_pop;
   assign desc_buf_rd_en = desc_pop;

   // Single output stage: load a forwarded beat, or empty when it has been accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         out_sop_reg   <= 1'b0;
         out_eop_reg   <= 1'b0;
         out_err_reg   <= 1'b0;
         out_data_reg  <= '0;
         out_dsc_reg   <= '0;
         out_pq_reg    <= '0;
         out_size_reg  <= '0;
      end else if (adv) begin
         out_valid_reg <= fwd;
         if (fwd) begin
            out_data_reg <= flit_data;
            out_sop_reg  <= first;
            out_eop_reg  <= beat_eop;
            out_err_reg  <= beat_eop && beat_err;
            // Tags travel with each beat, so a held beat keeps them even after
            // the next descriptor has been latched.
            out_dsc_reg  <= dsc_reg;
            out_pq_reg   <= pq_reg;
            out_size_reg <= size_reg;
         end
      end
   end

   // Saturating framing-error counter.
   always_ff @(posedge clk) begin
      if (!rst_n)
         err_cnt_reg <= '0;
      else if (err_inc && err_cnt_reg != {ERR_CNT_WIDTH{1'b1}})
         err_cnt_reg <= err_cnt_reg + 1'b1;
   end

   assign out_valid        = out_valid_reg;
   assign out_data         = out_data_reg;
   assign out_sop          = out_sop_reg;
   assign out_eop          = out_eop_reg;
   assign out_err          = out_err_reg;
   assign out_dsc_queue_id = out_dsc_reg;
   assign out_pkt_queue_id = out_pq_reg;
   assign out_size         = out_size_reg;
   assign err_cnt          = err_cnt_reg;

`ifdef F2C_DRAIN_STATS_EN
   logic [31:0] stat_pkt_reg, stat_flit_reg;

   // Wrap-around counters of beats and packets accepted downstream.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_pkt_reg  <= '0;
         stat_flit_reg <= '0;
      end else if (out_valid_reg && out_ready) begin
         stat_flit_reg <= stat_flit_reg + 32'd1;
         if (out_eop_reg)
            stat_pkt_reg <= stat_pkt_reg + 32'd1;
      end
   end

   assign stat_pkt_cnt  = stat_pkt_reg;
   assign stat_flit_cnt = stat_flit_reg;
`else
   assign stat_pkt_cnt  = 32'd0;
   assign stat_flit_cnt = 32'd0;
`endif

endmodule
